// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single line-granular main-memory port between the instruction
// cache (read-only) and the data cache (read and write-back). Round-robin
// arbitration; the grant is held for a whole transaction and released on
// main_mem's completion pulse, which is forwarded to the owning client.
//
// Optional feature macro: ARB_WB_LOCK_EN
//   When defined, a dcache read raised in the IDLE cycle right after a dcache
//   write-back completes wins regardless of round-robin order, so a
//   write-back plus refill pair cannot be split by the icache.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   i_rd_req/i_addr        icache line-read request (held until i_gnt)
//   i_gnt/i_rd_line        icache completion pulse and read line
//   d_rd_req/d_wr_req      dcache read / write-back requests
//   d_addr/d_wr_line       dcache line address and write-back data
//   d_gnt/d_rd_line        dcache completion pulse and read line
//   mem_*                  main-memory side (request, address, data, gnt)
//   owner                  00 idle, 01 icache, 10 dcache
//   i_wait_cnt/d_wait_cnt  saturating per-client wait-cycle counters
module mem_port_arbiter #(
    parameter int unsigned LINE_ADDR_LEN = 2,
    parameter int unsigned ADDR_LEN      = 10,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_rd_req,
    input  logic [ADDR_LEN-1:0]               i_addr,
    output logic                              i_gnt,
    output logic [(32 << LINE_ADDR_LEN)-1:0]  i_rd_line,
    input  logic                              d_rd_req,
    input  logic                              d_wr_req,
    input  logic [ADDR_LEN-1:0]               d_addr,
    input  logic [(32 << LINE_ADDR_LEN)-1:0]  d_wr_line,
    output logic                              d_gnt,
    output logic [(32 << LINE_ADDR_LEN)-1:0]  d_rd_line,
    output logic                              mem_rd_req,
    output logic                              mem_wr_req,
    output logic [ADDR_LEN-1:0]               mem_addr,
    output logic [(32 << LINE_ADDR_LEN)-1:0]  mem_wr_line,
    input  logic                              mem_gnt,
    input  logic [(32 << LINE_ADDR_LEN)-1:0]  mem_rd_line,
    output logic [1:0]                        owner,
    output logic [CNT_W-1:0]                  i_wait_cnt,
    output logic [CNT_W-1:0]                  d_wait_cnt
);

    localparam int unsigned LW = 32 << LINE_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;      // 1: dcache won last, 0: icache won last
    logic              w_last_d_nxt;
    logic              w_ireq;
    logic              w_dreq;
    logic              w_lock_d;      // dcache refill forced to win this IDLE cycle
    logic [CNT_W-1:0]  r_i_wait;
    logic [CNT_W-1:0]  r_d_wait;

    assign w_ireq = i_rd_req;
    assign w_dreq = d_rd_req | d_wr_req;

`ifdef ARB_WB_LOCK_EN
    logic r_wb_lock;

    // Set only for the IDLE cycle that follows a completed dcache write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_lock <= 1'b0;
        end else begin
            r_wb_lock <= (r_state == OWN_D) & mem_gnt & d_wr_req;
        end
    end

    assign w_lock_d = r_wb_lock & d_rd_req;
`else
    assign w_lock_d = 1'b0;
`endif

    // State and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_last_d <= w_last_d_nxt;
        end
    end

    // Arbitration, memory-side mux and grant pass-through.
    always_comb begin
        w_next       = r_state;
        w_last_d_nxt = r_last_d;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        mem_addr     = '0;
        mem_wr_line  = '0;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_lock_d) begin
                    w_next = OWN_D;
                end else if (w_ireq && w_dreq) begin
                    w_next = r_last_d ? OWN_I : OWN_D;
                end else if (w_ireq) begin
                    w_next = OWN_I;
                end else if (w_dreq) begin
                    w_next = OWN_D;
                end
            end
            OWN_I: begin
                mem_rd_req = i_rd_req;
                mem_addr   = i_addr;
                // A withdrawn request releases the port; a gnt with no request is ignored.
                if (!w_ireq) begin
                    w_next = IDLE;
                end else if (mem_gnt) begin
                    i_gnt        = 1'b1;
                    w_last_d_nxt = 1'b0;
                    w_next       = IDLE;
                end
            end
            OWN_D: begin
                mem_wr_req  = d_wr_req;
                mem_rd_req  = d_rd_req & ~d_wr_req;
                mem_addr    = d_addr;
                mem_wr_line = d_wr_line;
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (mem_gnt) begin
                    d_gnt        = 1'b1;
                    w_last_d_nxt = 1'b1;
                    w_next       = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Saturating wait counters; the IDLE arbitration cycle counts as waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_wait <= '0;
            r_d_wait <= '0;
        end else begin
            if (w_ireq && (r_state != OWN_I) && (r_i_wait != {CNT_W{1'b1}})) begin
                r_i_wait <= r_i_wait + CNT_W'(1);
            end
            if (w_dreq && (r_state != OWN_D) && (r_d_wait != {CNT_W{1'b1}})) begin
                r_d_wait <= r_d_wait + CNT_W'(1);
            end
        end
    end

    assign owner      = r_state;
    assign i_wait_cnt = r_i_wait;
    assign d_wait_cnt = r_d_wait;
    assign i_rd_line  = LW'(mem_rd_line);
    assign d_rd_line  = LW'(mem_rd_line);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a randomized
// transaction run checked through a scoreboard against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned LAL = 2;
    localparam int unsigned AL  = 10;
    localparam int unsigned CW  = 16;
    localparam int unsigned LW  = 32 << LAL;
    localparam int unsigned SAT = (1 << CW) - 1;
`ifdef ARB_WB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_rd_req;
    logic [AL-1:0] i_addr;
    logic          i_gnt;
    logic [LW-1:0] i_rd_line;
    logic          d_rd_req;
    logic          d_wr_req;
    logic [AL-1:0] d_addr;
    logic [LW-1:0] d_wr_line;
    logic          d_gnt;
    logic [LW-1:0] d_rd_line;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [AL-1:0] mem_addr;
    logic [LW-1:0] mem_wr_line;
    logic          mem_gnt;
    logic [LW-1:0] mem_rd_line;
    logic [1:0]    owner;
    logic [CW-1:0] i_wait_cnt;
    logic [CW-1:0] d_wait_cnt;

    mem_port_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rd_line(i_rd_line),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wr_line(d_wr_line),
        .d_gnt(d_gnt), .d_rd_line(d_rd_line),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_line(mem_wr_line), .mem_gnt(mem_gnt), .mem_rd_line(mem_rd_line),
        .owner(owner), .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    own;
        logic          gi;
        logic          gd;
        logic [CW-1:0] wi;
        logic [CW-1:0] wd;
    } cyc_t;

    typedef struct {
        logic [1:0]    own;
        logic [AL-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } tx_t;

    cyc_t cycq[$];
    tx_t  txq[$];
    int   checks   = 0;
    int   failures = 0;
    bit   sb_en    = 1'b0;

    // Transaction-level model of both clients, memory and the arbiter's policy.
    bit            ip, dp, dw, lock, refill;
    logic [AL-1:0] ia, da;
    logic [LW-1:0] dd, cur_rd;
    int            mo, mlast, lat;
    int unsigned   mwi, mwd;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        i_rd_req = 0; i_addr = '0; d_rd_req = 0; d_wr_req = 0; d_addr = '0;
        d_wr_line = '0; mem_gnt = 0; mem_rd_line = '0;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1;
        clr_inputs();
        nxt();
        rst = 0;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One randomized cycle: drive clients and memory, push expectations, advance model.
    task automatic rnd_cycle(input bit allow_new);
        bit   gnt, egi, egd;
        int   win;
        cyc_t c;
        tx_t  t;
        if (allow_new && !ip && $urandom_range(3) == 0) begin
            ip = 1; ia = AL'($urandom);
        end
        if (allow_new && !dp) begin
            if (refill) begin
                dp = 1; dw = 0; da = AL'($urandom);
            end else if ($urandom_range(3) == 0) begin
                dp = 1; dw = 1'($urandom_range(1)); da = AL'($urandom); dd = rnd_line();
            end
        end
        refill = 0;
        if (mo != 0) begin
            gnt = (lat == 0);
            if (lat != 0) lat--;
        end else begin
            gnt = ($urandom_range(7) == 0);
        end
        i_rd_req    = ip;
        i_addr      = ia;
        d_rd_req    = dp && !dw;
        d_wr_req    = dp && dw;
        d_addr      = da;
        d_wr_line   = dd;
        mem_gnt     = gnt;
        mem_rd_line = (mo != 0) ? cur_rd : rnd_line();
        egi = (mo == 1) && gnt && ip;
        egd = (mo == 2) && gnt && dp;
        c.own = 2'(mo); c.gi = egi; c.gd = egd; c.wi = CW'(mwi); c.wd = CW'(mwd);
        cycq.push_back(c);
        if (ip && mo != 1 && mwi < SAT) mwi++;
        if (dp && mo != 2 && mwd < SAT) mwd++;
        if (mo == 0) begin
            win = 0;
            if (LOCK_EN && lock && dp && !dw) win = 2;
            else if (ip && dp) win = (mlast == 1) ? 2 : 1;
            else if (ip) win = 1;
            else if (dp) win = 2;
            lock = 0;
            if (win != 0) begin
                cur_rd = rnd_line();
                lat    = $urandom_range(4);
                t.own   = 2'(win);
                t.addr  = (win == 1) ? ia : da;
                t.wr    = (win == 2) && dw;
                t.wdata = (win == 2) ? dd : '0;
                t.rdata = cur_rd;
                txq.push_back(t);
            end
            mo = win;
        end else if (egi || egd) begin
            mlast = mo;
            lock  = (mo == 2) && dw;
            if (mo == 1) begin
                ip = 0;
            end else begin
                if (dw && $urandom_range(1) == 1) refill = 1;
                dp = 0;
            end
            mo = 0;
        end
    endtask

    // Scoreboard monitor: per-cycle expectations plus per-transaction checks on each gnt.
    always @(negedge clk) begin
        cyc_t c;
        tx_t  t;
        if (sb_en) begin
            if (cycq.size() == 0) begin
                chk("cycq_underflow", 1, 0);
            end else begin
                c = cycq.pop_front();
                chk("sb_owner", LW'(owner), LW'(c.own));
                chk("sb_i_gnt", LW'(i_gnt), LW'(c.gi));
                chk("sb_d_gnt", LW'(d_gnt), LW'(c.gd));
                chk("sb_i_wait", LW'(i_wait_cnt), LW'(c.wi));
                chk("sb_d_wait", LW'(d_wait_cnt), LW'(c.wd));
            end
            if (i_gnt || d_gnt) begin
                if (txq.size() == 0) begin
                    chk("txq_underflow", 1, 0);
                end else begin
                    t = txq.pop_front();
                    chk("tx_client", LW'({d_gnt, i_gnt}), LW'(t.own));
                    chk("tx_addr", LW'(mem_addr), LW'(t.addr));
                    chk("tx_wr", LW'(mem_wr_req), LW'(t.wr));
                    chk("tx_rd", LW'(mem_rd_req), LW'(!t.wr));
                    chk("tx_wline", mem_wr_line, t.wdata);
                    chk("tx_rline", i_gnt ? i_rd_line : d_rd_line, t.rdata);
                end
            end
        end
    end

    initial begin
        logic [LW-1:0] pat;
        rst = 1;
        clr_inputs();

        // Reset state
        do_reset();
        smp();
        chk("rst_owner", LW'(owner), 0);
        chk("rst_gnts", LW'({i_gnt, d_gnt}), 0);
        chk("rst_mem_req", LW'({mem_rd_req, mem_wr_req}), 0);
        chk("rst_mem_addr", LW'(mem_addr), 0);
        chk("rst_mem_wline", mem_wr_line, 0);
        chk("rst_cnts", LW'({i_wait_cnt, d_wait_cnt}), 0);

        // Single icache read
        nxt(); i_rd_req = 1; i_addr = 10'h012;
        smp(); chk("t1_idle_owner", LW'(owner), 0);
        chk("t1_idle_noreq", LW'(mem_rd_req), 0);
        nxt(); smp();
        chk("t1_owner", LW'(owner), 1);
        chk("t1_rd_req", LW'(mem_rd_req), 1);
        chk("t1_addr", LW'(mem_addr), 10'h012);
        chk("t1_no_wr", LW'(mem_wr_req), 0);
        chk("t1_no_gnt_yet", LW'(i_gnt), 0);
        for (int k = 0; k < 3; k++) nxt();
        nxt(); mem_gnt = 1; pat = rnd_line(); mem_rd_line = pat;
        smp(); chk("t1_i_gnt", LW'(i_gnt), 1);
        chk("t1_d_gnt", LW'(d_gnt), 0);
        chk("t1_rd_line", i_rd_line, pat);
        nxt(); mem_gnt = 0; i_rd_req = 0;
        smp(); chk("t1_back_idle", LW'(owner), 0);
        chk("t1_gnt_1cyc", LW'(i_gnt), 0);
        chk("t1_i_wait", LW'(i_wait_cnt), 1);

        // Tie: icache first, dcache after one IDLE cycle, d_wait = 3 + 2
        do_reset();
        i_rd_req = 1; d_rd_req = 1; i_addr = 10'h100; d_addr = 10'h200;
        nxt(); smp(); chk("t2_i_first", LW'(owner), 1);
        nxt(); nxt(); mem_gnt = 1;
        smp(); chk("t2_i_gnt", LW'(i_gnt), 1);
        nxt(); mem_gnt = 0; i_rd_req = 0;
        smp(); chk("t2_idle_gap", LW'(owner), 0);
        nxt(); smp(); chk("t2_d_next", LW'(owner), 2);
        chk("t2_d_addr", LW'(mem_addr), 10'h200);
        chk("t2_d_wait", LW'(d_wait_cnt), 5);

        // Write-back then refill against a pending icache read
        do_reset();
        pat = {4{32'hA5A5A5A5}};
        d_wr_req = 1; d_addr = 10'h055; d_wr_line = pat;
        nxt(); i_rd_req = 1; i_addr = 10'h0AA; mem_gnt = 1;
        smp(); chk("t3_owner", LW'(owner), 2);
        chk("t3_wr_req", LW'(mem_wr_req), 1);
        chk("t3_rd_req", LW'(mem_rd_req), 0);
        chk("t3_addr", LW'(mem_addr), 10'h055);
        chk("t3_wline", mem_wr_line, pat);
        chk("t3_d_gnt", LW'(d_gnt), 1);
        nxt(); mem_gnt = 0; d_wr_req = 0; d_rd_req = 1;
        smp(); chk("t3_idle", LW'(owner), 0);
        nxt(); smp(); chk("t3_refill_winner", LW'(owner), LOCK_EN ? 2 : 1);

        // Withdraw without gnt keeps last_winner
        do_reset();
        d_rd_req = 1; d_addr = 10'h033;
        nxt(); smp(); chk("t4_owner_d", LW'(owner), 2);
        nxt(); d_rd_req = 0;
        smp(); chk("t4_no_d_gnt", LW'(d_gnt), 0);
        nxt(); i_rd_req = 1; d_rd_req = 1;
        smp(); chk("t4_idle", LW'(owner), 0);
        nxt(); smp(); chk("t4_tie_to_i", LW'(owner), 1);

        // Reset during OWN_D, then a stray mem_gnt
        do_reset();
        d_rd_req = 1; d_addr = 10'h3AA;
        nxt(); i_rd_req = 1; rst = 1;
        smp(); chk("t5_owner_d", LW'(owner), 2);
        chk("t5_addr", LW'(mem_addr), 10'h3AA);
        nxt(); rst = 0; i_rd_req = 0; d_rd_req = 0; mem_gnt = 1;
        smp(); chk("t5_owner", LW'(owner), 0);
        chk("t5_mem_req", LW'({mem_rd_req, mem_wr_req}), 0);
        chk("t5_mem_addr", LW'(mem_addr), 0);
        chk("t5_no_gnt", LW'({i_gnt, d_gnt}), 0);
        chk("t5_cnts", LW'({i_wait_cnt, d_wait_cnt}), 0);
        nxt(); mem_gnt = 0;

        // Wait counter saturation
        do_reset();
        d_rd_req = 1;
        nxt(); i_rd_req = 1;
        for (int k = 0; k < 70000; k++) nxt();
        smp(); chk("t6_i_sat", LW'(i_wait_cnt), LW'(SAT));
        chk("t6_d_wait", LW'(d_wait_cnt), 1);
        chk("t6_owner", LW'(owner), 2);

        // Randomized run through the scoreboard
        do_reset();
        ip = 0; dp = 0; dw = 0; lock = 0; refill = 0; ia = '0; da = '0; dd = '0;
        cur_rd = '0; mo = 0; mlast = 2; lat = 0; mwi = 0; mwd = 0;
        sb_en = 1;
        rnd_cycle(1);
        for (int k = 0; k < 3000; k++) begin
            nxt(); rnd_cycle(1);
        end
        for (int k = 0; k < 200 && (ip || dp || mo != 0); k++) begin
            nxt(); rnd_cycle(0);
        end
        nxt(); sb_en = 0;
        chk("rnd_drained", LW'(ip || dp || mo != 0), 0);
        chk("rnd_txq_empty", LW'(txq.size()), 0);
        chk("rnd_cycq_empty", LW'(cycq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single line-granular main-memory port between the instruction cache (read-only) and the data cache (read and write-back).
- Sits between both cache miss engines and main_mem.
- Uses round-robin arbitration and holds the grant for a whole transaction.
- Forwards main_mem's one-cycle gnt pulse back to the owning client, and counts per-client wait cycles for performance analysis.

Parameters:
- LINE_ADDR_LEN, 2, log2 of words per line; line bus width LW = 32 << LINE_ADDR_LEN.
- ADDR_LEN, 10, line address width into main memory.
- CNT_W, 16, width of the saturating wait counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high, sampled on the rising edge of clk.
- i_rd_req  in  1  icache line-read request, held until i_gnt.
- i_addr  in  ADDR_LEN  icache line address.
- i_gnt  out  1  one-cycle completion pulse to the icache.
- i_rd_line  out  LW  read line to the icache; equals mem_rd_line.
- d_rd_req  in  1  dcache line-read request.
- d_wr_req  in  1  dcache line write-back request.
- d_addr  in  ADDR_LEN  dcache line address.
- d_wr_line  in  LW  dcache write-back data.
- d_gnt  out  1  one-cycle completion pulse to the dcache.
- d_rd_line  out  LW  read line to the dcache; equals mem_rd_line.
- mem_rd_req  out  1  to main_mem.
- mem_wr_req  out  1  to main_mem.
- mem_addr  out  ADDR_LEN  to main_mem.
- mem_wr_line  out  LW  to main_mem.
- mem_gnt  in  1  main_mem completion pulse.
- mem_rd_line  in  LW  main_mem read data.
- owner  out  2  2'b00 idle, 2'b01 icache, 2'b10 dcache.
- i_wait_cnt  out  CNT_W  cycles icache requested while not owner; saturating.
- d_wait_cnt  out  CNT_W  same for the dcache.

Behaviour:
- States: IDLE, OWN_I, OWN_D. State and last_winner are registered. All memory-side outputs are combinational muxes of the owner's inputs.
- Reset (rst=1 at an edge):
  - State goes to IDLE and last_winner to D, so the icache wins the first tie.
  - Both wait counters clear to 0.
  - Outputs: owner=0; i_gnt=d_gnt=0; mem_rd_req=mem_wr_req=0; mem_addr=0; mem_wr_line=0.
  - Reset applies mid-transaction too. Any in-flight memory request is dropped; main_mem's gnt seen during IDLE is ignored.
- IDLE:
  - ireq = i_rd_req; dreq = d_rd_req | d_wr_req.
  - If only one is asserted, go to that client's OWN state.
  - If both are asserted, go to the client that is not last_winner.
  - No memory request is driven in IDLE. Grant latency is 1 cycle: a request first seen at edge N appears on mem_* in cycle N+1.
- OWN_I:
  - mem_rd_req=i_rd_req, mem_wr_req=0, mem_addr=i_addr.
  - On mem_gnt: i_gnt=1 in the same cycle (combinational pass-through), last_winner<=I, next state IDLE.
- OWN_D:
  - mem_wr_req=d_wr_req, mem_rd_req=d_rd_req & ~d_wr_req (write has priority if both are asserted), mem_addr=d_addr, mem_wr_line=d_wr_line.
  - On mem_gnt: d_gnt=1, last_winner<=D, next state IDLE.
- Client withdraws its request while owner with no mem_gnt: next state IDLE, no gnt issued, last_winner unchanged.
- mem_gnt while IDLE, or arriving with the owner's request low: ignored, no client gnt.
- Back-to-back use: a client re-raising its request the cycle after its gnt goes through IDLE again, costing 1 idle cycle. Round-robin lets a waiting peer win that turn.
- Wait counters: increment by 1 each cycle the client requests and owner is not that client, including the IDLE arbitration cycle. They saturate at 2^CNT_W-1 and never wrap.

Optional Feature:
- Macro: ARB_WB_LOCK_EN.
- Defined: after d_gnt for a write (d_wr_req=1), if d_rd_req is asserted in the following IDLE cycle, the dcache wins regardless of last_winner. This makes a write-back plus refill atomic.
- Undefined: plain round-robin; the icache can interleave between write-back and refill.

Test Plan:
- Reset then i_rd_req=1, i_addr=0x012; mem_gnt pulsed 4 cycles after owner=01 -> mem_rd_req=1 and mem_addr=0x012 from cycle 1; i_gnt exactly 1 cycle; i_rd_line=mem_rd_line; then owner returns to 00.
- i_rd_req and d_rd_req both rise in the same cycle after reset -> icache served first; dcache next after one IDLE cycle; d_wait_cnt equals icache service length +2.
- d_wr_req=1, d_addr=0x055, d_wr_line=0xA5A5… -> mem_wr_req=1, mem_rd_req=0, mem_wr_line matches; on d_gnt the dcache drops wr and raises rd with i_rd_req pending -> icache wins (lock macro off) / dcache wins (ARB_WB_LOCK_EN on).
- Owner dcache; d_rd_req deasserted with no mem_gnt -> IDLE next cycle; d_gnt stays 0; last_winner unchanged, so a following tie goes to the icache.
- rst asserted mid-OWN_D -> next cycle all outputs 0, counters 0; a stray mem_gnt the next cycle produces no i_gnt/d_gnt.
- Hold i_rd_req while the dcache owns the port for 70000 cycles with CNT_W=16 -> i_wait_cnt saturates at 0xFFFF.
